// File: rtl/nvram_bk_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nvram_bk_ctrl
//  Description : Backup-RAM save/load sequencer. Streams 2^SECT_W consecutive
//                512-byte sectors between the core NVRAM and one of 2^SLOT_W
//                slots of the mounted save image, with dirty tracking and an
//                idle-timed autosave.
//  Ports       : clk_sys/reset       - clock, synchronous active-high reset
//                bk_ena              - image mounted and writable, gates starts
//                load_req/save_req   - level requests, rising edge starts
//                mount_load          - one-cycle pulse, starts a load
//                slot                - slot select, latched at start
//                autosave_en         - enables idle-timed autosave
//                nvram_we            - NVRAM write strobe, sets dirty
//                sd_ack              - host sector acknowledge
//                sd_lba/sd_rd/sd_wr  - sector address and requests
//                bk_loading/bk_busy  - load / any transfer in progress
//                dirty/done          - modified flag, completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module nvram_bk_ctrl #(
    parameter int               SECT_W       = 6,
    parameter int               SLOT_W       = 2,
    parameter int               IDLE_W       = 24,
    parameter logic [IDLE_W-1:0] AUTOSAVE_CYC = IDLE_W'(10_000_000)
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              bk_ena,
    input  logic              load_req,
    input  logic              save_req,
    input  logic              mount_load,
    input  logic [SLOT_W-1:0] slot,
    input  logic              autosave_en,
    input  logic              nvram_we,
    input  logic              sd_ack,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    output logic              bk_loading,
    output logic              bk_busy,
    output logic              dirty,
    output logic              done
);

    generate
        if (SLOT_W + SECT_W > 32) begin : g_width_check
            $error("nvram_bk_ctrl: SLOT_W + SECT_W must not exceed 32");
        end
    endgenerate

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_XFER = 2'd2;
    localparam logic [1:0] c_ST_FIN  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_load_lvl;
    logic              r_save_lvl;
    logic              r_old_ack;
    logic [SLOT_W-1:0] r_slot_q;
    logic [SECT_W-1:0] r_sector;
    logic              r_is_load;
    logic              r_wr_during;
    logic              r_dirty;
    logic [IDLE_W-1:0] r_idle_cnt;

    logic w_load_lvl, w_save_lvl, w_load_edge, w_save_edge;
    logic w_start_load, w_autosave, w_start_any;
    logic w_ack_rise, w_ack_fall, w_last;
    logic [31:0] w_lba;

    assign w_load_lvl   = load_req & bk_ena;
    assign w_save_lvl   = save_req & bk_ena;
    assign w_load_edge  = w_load_lvl & ~r_load_lvl;
    assign w_save_edge  = w_save_lvl & ~r_save_lvl;
    // Load sources outrank save sources; autosave is the lowest priority.
    assign w_start_load = (mount_load & bk_ena) | w_load_edge;
    assign w_autosave   = autosave_en & bk_ena & r_dirty &
                          (r_idle_cnt >= AUTOSAVE_CYC);
    assign w_start_any  = w_start_load | w_save_edge | w_autosave;
    assign w_ack_rise   = sd_ack & ~r_old_ack;
    assign w_ack_fall   = ~sd_ack & r_old_ack;
    assign w_last       = &r_sector;
    assign w_lba        = (32'(r_slot_q) << SECT_W) | 32'(r_sector);

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_start_any) w_state_nxt = c_ST_REQ;
            c_ST_REQ:  if (w_ack_rise)  w_state_nxt = c_ST_XFER;
            c_ST_XFER: if (w_ack_fall)  w_state_nxt = w_last ? c_ST_FIN : c_ST_REQ;
            default:                    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        sd_lba     = w_lba;
        sd_rd      = 1'b0;
        sd_wr      = 1'b0;
        bk_busy    = 1'b0;
        bk_loading = 1'b0;
        done       = 1'b0;
        dirty      = r_dirty;
        case (r_state)
            c_ST_REQ: begin
                sd_rd      = r_is_load;
                sd_wr      = ~r_is_load;
                bk_busy    = 1'b1;
                bk_loading = r_is_load;
            end
            c_ST_XFER: begin
                bk_busy    = 1'b1;
                bk_loading = r_is_load;
            end
            c_ST_FIN: done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: edge registers, sector/slot, dirty tracking, idle counter
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_load_lvl  <= 1'b0;
            r_save_lvl  <= 1'b0;
            r_old_ack   <= 1'b0;
            r_slot_q    <= '0;
            r_sector    <= '0;
            r_is_load   <= 1'b0;
            r_wr_during <= 1'b0;
            r_dirty     <= 1'b0;
            r_idle_cnt  <= '0;
        end else begin
            r_load_lvl <= w_load_lvl;
            r_save_lvl <= w_save_lvl;
            r_old_ack  <= sd_ack;

            if (r_state == c_ST_IDLE && w_start_any) begin
                r_slot_q    <= slot;
                r_sector    <= '0;
                r_is_load   <= w_start_load;
                // A write in the start cycle already makes the saved image stale.
                r_wr_during <= nvram_we;
            end else begin
                if (r_state == c_ST_XFER && w_ack_fall && !w_last) begin
                    r_sector <= r_sector + SECT_W'(1);
                end
                if (nvram_we && r_state != c_ST_IDLE) begin
                    r_wr_during <= 1'b1;
                end
            end

            // A write in the completion cycle wins over the clear.
            if (nvram_we) begin
                r_dirty <= 1'b1;
            end else if (r_state == c_ST_FIN && (r_is_load || !r_wr_during)) begin
                r_dirty <= 1'b0;
            end

            if (nvram_we || r_state != c_ST_IDLE) begin
                r_idle_cnt <= '0;
            end else if (r_dirty && !(&r_idle_cnt)) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
